// File: rtl/dvi_fifo_writer_pkg.sv
// Shared definitions for the DVI pixel FIFO writer and reader.
// FIFO word layout, coordinate widths and FSM state encoding.
package dvi_fifo_writer_pkg;

  localparam int WORD_W = 44;
  localparam int CNT_W  = 10;

  localparam int X_MSB = 43;
  localparam int Y_MSB = 33;
  localparam int R_MSB = 23;
  localparam int G_MSB = 15;
  localparam int B_MSB = 7;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;

  typedef logic [CNT_W-1:0] coord_t;

  typedef enum logic {
    S_WAIT_VS = 1'b0,
    S_ACTIVE  = 1'b1
  } wr_state_e;

  function automatic logic [WORD_W-1:0] pack_word(
    input coord_t     x,
    input coord_t     y,
    input logic [7:0] r,
    input logic [7:0] g,
    input logic [7:0] b
  );
    return {x, y, r, g, b};
  endfunction

endpackage

// File: rtl/dvi_fifo_writer_coord.sv
// Active-area x/y position tracker for the DVI FIFO writer.
// Flags the last pixel of a frame as it is stepped past.
module pixel_coord_counter
  import dvi_fifo_writer_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE
) (
  input  logic   clk_25,
  input  logic   rst_n,
  input  logic   clear,
  input  logic   step,
  output coord_t x,
  output coord_t y,
  output logic   at_origin,
  output logic   frame_end
);

  localparam coord_t X_LAST = CNT_W'(H_ACTIVE - 1);
  localparam coord_t Y_LAST = CNT_W'(V_ACTIVE - 1);

  logic x_wrap;
  logic y_wrap;

  assign x_wrap    = (x == X_LAST);
  assign y_wrap    = (y == Y_LAST);
  assign at_origin = (x == '0) && (y == '0);
  assign frame_end = step & x_wrap & y_wrap;

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (step) begin
      if (x_wrap) begin
        x <= '0;
        y <= y_wrap ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dvi_fifo_writer.sv
// DVI capture front end: tags pixels with x/y and feeds a FIFO.
// Optional statistics counters: define DVI_WRITER_STATS_EN.
module dvi_fifo_writer
  import dvi_fifo_writer_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE
) (
  input  logic              clk_25,
  input  logic              rst_n,
  input  logic              vsync,
  input  logic              de,
  input  logic [7:0]        pix_r,
  input  logic [7:0]        pix_g,
  input  logic [7:0]        pix_b,
  input  logic              wrfull,
  input  logic              clr,
  output logic              wrclk,
  output logic              wrreq,
  output logic [WORD_W-1:0] data,
  output logic              frame_done,
  output logic              overflow,
`ifdef DVI_WRITER_STATS_EN
  output logic [15:0]       drop_cnt,
  output logic [7:0]        frame_cnt,
`endif
  output logic              frame_err
);

  wr_state_e state;
  wr_state_e state_nxt;

  logic vs_prev;
  logic vs_rise;
  logic active;
  logic coord_clr;
  logic ferr_set;
  logic pix_ev;
  logic load;
  logic drop;
  logic hold_vld;
  logic at_origin;
  logic frame_end;
  coord_t x;
  coord_t y;
  logic [WORD_W-1:0] hold_word;

  assign wrclk   = clk_25;
  assign vs_rise = vsync & ~vs_prev;
  assign pix_ev  = active & de & ~vsync;
  assign wrreq   = hold_vld & ~wrfull;
  // A write this cycle frees the slot for a new pixel
  assign load    = pix_ev & (~hold_vld | wrreq);
  assign drop    = pix_ev & ~load;
  assign data    = hold_word;

  pixel_coord_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_coord (
    .clk_25    (clk_25),
    .rst_n     (rst_n),
    .clear     (coord_clr),
    .step      (pix_ev),
    .x         (x),
    .y         (y),
    .at_origin (at_origin),
    .frame_end (frame_end)
  );

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) state <= S_WAIT_VS;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      (state == S_WAIT_VS):
        if (vs_rise) state_nxt = S_ACTIVE;
      (state == S_ACTIVE):
        if (frame_end) state_nxt = S_WAIT_VS;
      default: state_nxt = S_WAIT_VS;
    endcase
  end

  always_comb begin
    active    = 1'b0;
    coord_clr = 1'b0;
    ferr_set  = 1'b0;
    unique case (1'b1)
      (state == S_WAIT_VS): begin
        coord_clr = vs_rise;
      end
      (state == S_ACTIVE): begin
        active    = 1'b1;
        coord_clr = vs_rise;
        ferr_set  = vs_rise & ~at_origin;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      vs_prev    <= 1'b0;
      hold_vld   <= 1'b0;
      hold_word  <= '0;
      frame_done <= 1'b0;
    end else begin
      vs_prev    <= vsync;
      frame_done <= frame_end;
      if (load) begin
        hold_vld  <= 1'b1;
        hold_word <= pack_word(x, y, pix_r, pix_g, pix_b);
      end else if (wrreq) begin
        hold_vld  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (drop)     overflow <= 1'b1;
      else if (clr) overflow <= 1'b0;
      if (ferr_set) frame_err <= 1'b1;
      else if (clr) frame_err <= 1'b0;
    end
  end

`ifdef DVI_WRITER_STATS_EN
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt  <= '0;
      frame_cnt <= '0;
    end else begin
      if (clr)
        drop_cnt <= {15'd0, drop};
      else if (drop && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
      if (clr)
        frame_cnt <= {7'd0, frame_done};
      else if (frame_done)
        frame_cnt <= frame_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dvi_fifo_writer.sv
// Scoreboard bench for dvi_fifo_writer on a 4x2 frame.
// Driver feeds a frame-level model; monitor checks DUT at negedge.
module tb_dvi_fifo_writer;

  localparam int H = 4;
  localparam int V = 2;
  localparam int NPIX = H * V;

  logic        clk_25 = 1'b0;
  logic        rst_n  = 1'b0;
  logic        vsync  = 1'b0;
  logic        de     = 1'b0;
  logic [7:0]  pix_r  = '0;
  logic [7:0]  pix_g  = '0;
  logic [7:0]  pix_b  = '0;
  logic        wrfull = 1'b0;
  logic        clr    = 1'b0;
  logic        wrclk;
  logic        wrreq;
  logic [43:0] data;
  logic        frame_done;
  logic        overflow;
  logic        frame_err;
`ifdef DVI_WRITER_STATS_EN
  logic [15:0] drop_cnt;
  logic [7:0]  frame_cnt;
`endif

  dvi_fifo_writer #(
    .H_ACTIVE (H),
    .V_ACTIVE (V)
  ) dut (
    .clk_25     (clk_25),
    .rst_n      (rst_n),
    .vsync      (vsync),
    .de         (de),
    .pix_r      (pix_r),
    .pix_g      (pix_g),
    .pix_b      (pix_b),
    .wrfull     (wrfull),
    .clr        (clr),
    .wrclk      (wrclk),
    .wrreq      (wrreq),
    .data       (data),
    .frame_done (frame_done),
    .overflow   (overflow),
`ifdef DVI_WRITER_STATS_EN
    .drop_cnt   (drop_cnt),
    .frame_cnt  (frame_cnt),
`endif
    .frame_err  (frame_err)
  );

  always #20 clk_25 = ~clk_25;

  int tests = 0;
  int fails = 0;

  // Reference model: frame position as a linear pixel index
  logic        m_act;
  int          m_n;
  logic        m_vsp;
  logic        m_occ;
  logic        m_ovf;
  logic        m_ferr;
  logic        m_fdone;
  int          m_dropc;
  int          m_framec;
  logic        exp_wrreq;
  logic        chk_en = 1'b0;
  logic [43:0] sb[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_act = 0; m_n = 0; m_vsp = 0; m_occ = 0;
    m_ovf = 0; m_ferr = 0; m_fdone = 0;
    m_dropc = 0; m_framec = 0;
    exp_wrreq = 0;
    sb.delete();
  endtask

  task automatic cycle(input logic d, input logic v,
                       input logic f, input logic c,
                       input logic [7:0] r, input logic [7:0] g,
                       input logic [7:0] b);
    logic wr, vsr, pix, acc, drp;
    de = d; vsync = v; wrfull = f; clr = c;
    pix_r = r; pix_g = g; pix_b = b;
    wr  = m_occ && !f;
    vsr = v && !m_vsp;
    pix = m_act && d && !v;
    acc = pix && (!m_occ || wr);
    drp = pix && !acc;
    exp_wrreq = wr;
    if (acc)
      sb.push_back({10'(m_n % H), 10'(m_n / H), r, g, b});
    @(posedge clk_25);
    if (c) m_dropc = drp ? 1 : 0;
    else if (drp && m_dropc != 16'hFFFF) m_dropc++;
    if (c) m_framec = m_fdone ? 1 : 0;
    else if (m_fdone) m_framec = (m_framec + 1) % 256;
    m_fdone = pix && (m_n == NPIX - 1);
    if (drp) m_ovf = 1;
    else if (c) m_ovf = 0;
    if (vsr && m_act && m_n != 0) m_ferr = 1;
    else if (c) m_ferr = 0;
    if (acc) m_occ = 1;
    else if (wr) m_occ = 0;
    if (vsr) begin
      m_act = 1; m_n = 0;
    end else if (pix) begin
      if (m_n == NPIX - 1) begin
        m_n = 0; m_act = 0;
      end else begin
        m_n++;
      end
    end
    m_vsp = v;
    #1;
  endtask

  task automatic idle(input int n, input logic f);
    for (int i = 0; i < n; i++)
      cycle(0, 0, f, 0, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic vs_pulse();
    cycle(0, 1, 0, 0, 8'h00, 8'h00, 8'h00);
    cycle(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic do_reset();
    chk_en = 0;
    @(negedge clk_25);
    #1;
    rst_n = 0;
    model_reset();
    #1;
    chk("rst_wrreq", 64'(wrreq), 64'd0);
    chk("rst_data", 64'(data), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_ferr", 64'(frame_err), 64'd0);
    chk("rst_fdone", 64'(frame_done), 64'd0);
    repeat (2) @(posedge clk_25);
    #1;
    rst_n = 1;
    chk_en = 1;
  endtask

  // Monitor: every cycle checks handshake and flags, pops on writes
  initial begin
    logic [43:0] e;
    forever begin
      @(negedge clk_25);
      if (chk_en) begin
        chk("wrreq", 64'(wrreq), 64'(exp_wrreq));
        chk("frame_done", 64'(frame_done), 64'(m_fdone));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("frame_err", 64'(frame_err), 64'(m_ferr));
`ifdef DVI_WRITER_STATS_EN
        chk("drop_cnt", 64'(drop_cnt), 64'(m_dropc));
        chk("frame_cnt", 64'(frame_cnt), 64'(m_framec));
`endif
        if (wrreq) begin
          if (sb.size() == 0) begin
            chk("sb_underflow", 64'(data), 64'hDEAD);
          end else begin
            e = sb.pop_front();
            chk("data", 64'(data), 64'(e));
          end
        end
      end
    end
  end

  initial begin
    logic v, d, f, c;
    int vs_hold;
    model_reset();
    do_reset();

    // Four pixels then the rest of the 4x2 frame
    vs_pulse();
    for (int i = 0; i < 4; i++)
      cycle(1, 0, 0, 0, 8'h11, 8'h22, 8'h33);
    for (int i = 0; i < 4; i++)
      cycle(1, 0, 0, 0, 8'(i), 8'(i + 8'h40), 8'h5A);
    idle(1, 0);
    chk("frame_done_pulse_gone", 64'(frame_done), 64'd0);
    cycle(1, 0, 0, 0, 8'hEE, 8'hEE, 8'hEE);
    idle(2, 0);

    // FIFO full across three pixels
    vs_pulse();
    for (int i = 0; i < 3; i++)
      cycle(1, 0, 1, 0, 8'(i + 1), 8'h00, 8'hFF);
    idle(1, 1);
    chk("ovf_set", 64'(overflow), 64'd1);
    idle(3, 0);
    chk("ovf_sticky", 64'(overflow), 64'd1);
    cycle(0, 0, 0, 1, 8'h00, 8'h00, 8'h00);
    chk("ovf_clr", 64'(overflow), 64'd0);

    // vsync in the middle of a frame
    vs_pulse();
    for (int i = 0; i < 5; i++)
      cycle(1, 0, 0, 0, 8'hA0, 8'(i), 8'h0C);
    vs_pulse();
    chk("ferr_set", 64'(frame_err), 64'd1);
    cycle(1, 0, 0, 0, 8'h77, 8'h66, 8'h55);
    idle(1, 0);
    cycle(0, 0, 0, 1, 8'h00, 8'h00, 8'h00);
    chk("ferr_clr", 64'(frame_err), 64'd0);

    // vsync held high with de: no pixel
    cycle(1, 1, 0, 0, 8'h99, 8'h99, 8'h99);
    cycle(1, 1, 0, 0, 8'h98, 8'h98, 8'h98);
    cycle(1, 0, 0, 0, 8'h12, 8'h34, 8'h56);
    idle(2, 0);
    chk("vs_de_no_ovf", 64'(overflow), 64'd0);

    // Reset with a word parked behind a full FIFO
    vs_pulse();
    cycle(1, 0, 1, 0, 8'hC1, 8'hC2, 8'hC3);
    idle(1, 1);
    do_reset();
    idle(1, 0);
    for (int i = 0; i < 3; i++)
      cycle(1, 0, 0, 0, 8'hD0, 8'hD1, 8'hD2);
    chk("post_rst_no_wr", 64'(wrreq), 64'd0);
    vs_pulse();
    cycle(1, 0, 0, 0, 8'hE1, 8'hE2, 8'hE3);
    idle(1, 0);

    // Random traffic
    vs_hold = 0;
    for (int i = 0; i < 4000; i++) begin
      if (vs_hold > 0) begin
        v = 1; vs_hold--;
      end else if ($urandom_range(0, 29) == 0) begin
        v = 1; vs_hold = $urandom_range(0, 2);
      end else begin
        v = 0;
      end
      d = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 3) == 0);
      c = ($urandom_range(0, 19) == 0);
      cycle(d, v, f, c, 8'($urandom), 8'($urandom),
            8'($urandom));
    end
    idle(3, 0);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    chk_en = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
